// File: rtl/lvc_ahb_pkg.sv
// Shared AHB type definitions for the lvc_ahb environment, plus the
// arbiter FSM state encoding and the burst length helper.
package lvc_ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } trans_type_enum;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } burst_type_enum;

  typedef enum logic [1:0] {
    OKAY  = 2'd0,
    ERROR = 2'd1,
    RETRY = 2'd2,
    SPLIT = 2'd3
  } response_type_enum;

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_BURST  = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_e;

  localparam int CNT_W = 4;

  // Beat count of a burst; 0 marks INCR, whose length is undefined.
  function automatic logic [4:0] burst_len(input burst_type_enum b);
    case (b)
      SINGLE:         burst_len = 5'd1;
      INCR:           burst_len = 5'd0;
      WRAP4, INCR4:   burst_len = 5'd4;
      WRAP8, INCR8:   burst_len = 5'd8;
      default:        burst_len = 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/lvc_ahb_rr_picker.sv
// Combinational round-robin selector: first requester after i_ptr, wrapping,
// with i_ptr itself considered last.
module lvc_ahb_rr_picker #(
  parameter int NUM_MST = 4,
  parameter int MW      = $clog2(NUM_MST)
) (
  input  logic [NUM_MST-1:0] i_req,
  input  logic [MW-1:0]      i_ptr,
  output logic [MW-1:0]      o_winner,
  output logic               o_valid
);

  always_comb begin
    logic [MW-1:0] idx;
    o_winner = '0;
    o_valid  = 1'b0;
    idx      = '0;
    for (int i = 1; i <= NUM_MST; i++) begin
      idx = MW'((int'(i_ptr) + i) % NUM_MST);
      if (!o_valid && i_req[idx]) begin
        o_valid  = 1'b1;
        o_winner = idx;
      end
    end
  end

endmodule

// File: rtl/lvc_ahb_arbiter.sv
// Multi-master AHB arbiter: round robin with burst/lock-aware handover,
// registered one-hot grant and address/data-phase owner indices.
module lvc_ahb_arbiter
  import lvc_ahb_pkg::*;
#(
  parameter int NUM_MST     = 4,
  parameter int DEFAULT_MST = 0,
  parameter int MW          = $clog2(NUM_MST)
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic [NUM_MST-1:0] hbusreq,
  input  logic [NUM_MST-1:0] hlock,
  input  logic [1:0]         htrans,
  input  logic [2:0]         hburst,
  input  logic               hready,
  input  logic [1:0]         hresp,
  output logic [NUM_MST-1:0] hgrant,
  output logic [MW-1:0]      hmaster,
  output logic [MW-1:0]      hmaster_d,
  output logic               hmastlock,
  output arb_state_e         o_dbg_state,
  output logic [CNT_W-1:0]   o_dbg_cnt
);

  localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MST);

  arb_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [MW-1:0]    r_gidx;   // grant index, doubles as the RR pointer
  logic             r_incr;   // granted master is running an INCR burst

  trans_type_enum    w_trans;
  burst_type_enum    w_burst;
  response_type_enum w_resp;
  logic [MW-1:0]     w_rr_idx, w_rr_winner, w_winner;
  logic              w_rr_valid, w_fixed, w_incr_eff, w_keep;
  logic              w_lock_start, w_burst_end, w_lock_end, w_abort;
  logic [CNT_W-1:0]  w_len_m1;

  assign w_trans = trans_type_enum'(htrans);
  assign w_burst = burst_type_enum'(hburst);
  assign w_resp  = response_type_enum'(hresp);

  lvc_ahb_rr_picker #(.NUM_MST(NUM_MST), .MW(MW)) u_pick (
    .i_req    (hbusreq),
    .i_ptr    (r_gidx),
    .o_winner (w_rr_idx),
    .o_valid  (w_rr_valid)
  );

  assign w_fixed      = (burst_len(w_burst) >= 5'd4);
  assign w_len_m1     = CNT_W'(burst_len(w_burst) - 5'd1);
  assign w_rr_winner  = w_rr_valid ? w_rr_idx : DEF_IDX;
  // An INCR owner keeps the bus for as long as it keeps requesting.
  assign w_incr_eff   = (w_trans == NONSEQ) ? (w_burst == INCR) : r_incr;
  assign w_keep       = w_incr_eff && hbusreq[r_gidx];
  assign w_winner     = w_keep ? r_gidx : w_rr_winner;
  assign w_lock_start = (w_trans == NONSEQ) && hlock[r_gidx];
  assign w_burst_end  = ((w_trans == SEQ) && (r_cnt <= CNT_W'(1))) ||
                        (w_trans == IDLE) || (w_trans == NONSEQ);
  assign w_lock_end   = !hlock[r_gidx] && ((w_trans == IDLE) || (w_trans == NONSEQ));
  assign w_abort      = (w_resp != OKAY);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state   <= ST_ARB;
      r_cnt     <= '0;
      r_gidx    <= DEF_IDX;
      r_incr    <= 1'b0;
      hgrant    <= NUM_MST'(1) << DEF_IDX;
      hmaster   <= DEF_IDX;
      hmaster_d <= DEF_IDX;
      hmastlock <= 1'b0;
    end else if (hready) begin
      hmaster   <= r_gidx;
      hmaster_d <= hmaster;
      hmastlock <= hlock[r_gidx];
      if ((w_trans == NONSEQ) && w_fixed) r_cnt <= w_len_m1;
      else if ((w_trans == SEQ) && (r_cnt != '0)) r_cnt <= r_cnt - CNT_W'(1);
      if (w_trans == NONSEQ) r_incr <= (w_burst == INCR);
      // A non-OKAY response ends any burst or lock and re-arbitrates at once.
      if (w_abort) begin
        r_state <= ST_ARB;
        r_cnt   <= '0;
        r_incr  <= 1'b0;
        hgrant  <= NUM_MST'(1) << w_rr_winner;
        r_gidx  <= w_rr_winner;
      end else begin
        case (r_state)
          ST_ARB: begin
            if (w_lock_start) r_state <= ST_LOCKED;
            else if ((w_trans == NONSEQ) && w_fixed) r_state <= ST_BURST;
            else begin
              hgrant <= NUM_MST'(1) << w_winner;
              r_gidx <= w_winner;
              if (w_winner != r_gidx) r_incr <= 1'b0;
            end
          end
          ST_BURST: begin
            if (w_lock_start) r_state <= ST_LOCKED;
            else if (w_burst_end) begin
              r_state <= ST_ARB;
              r_cnt   <= '0;
              hgrant  <= NUM_MST'(1) << w_winner;
              r_gidx  <= w_winner;
              if (w_winner != r_gidx) r_incr <= 1'b0;
            end
          end
          ST_LOCKED: begin
            if (w_lock_end) begin
              r_state <= ST_ARB;
              r_cnt   <= '0;
              hgrant  <= NUM_MST'(1) << w_winner;
              r_gidx  <= w_winner;
              if (w_winner != r_gidx) r_incr <= 1'b0;
            end
          end
          default: r_state <= ST_ARB;
        endcase
      end
    end
  end

  assign o_dbg_state = r_state;
  assign o_dbg_cnt   = r_cnt;

endmodule

// File: tb/tb_lvc_ahb_arbiter.sv
// Directed bench for lvc_ahb_arbiter: reset, round robin, INCR ownership,
// fixed bursts, locking, RETRY abort and asynchronous reset mid-burst.
module tb_lvc_ahb_arbiter;
  import lvc_ahb_pkg::*;

  logic       hclk = 1'b0;
  logic       hresetn;
  logic [3:0] hbusreq, hlock;
  logic [1:0] htrans, hresp;
  logic [2:0] hburst;
  logic       hready;
  logic [3:0] hgrant;
  logic [1:0] hmaster, hmaster_d;
  logic       hmastlock;
  arb_state_e dbg_state;
  logic [3:0] dbg_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  lvc_ahb_arbiter #(.NUM_MST(4), .DEFAULT_MST(0)) dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .hbusreq     (hbusreq),
    .hlock       (hlock),
    .htrans      (htrans),
    .hburst      (hburst),
    .hready      (hready),
    .hresp       (hresp),
    .hgrant      (hgrant),
    .hmaster     (hmaster),
    .hmaster_d   (hmaster_d),
    .hmastlock   (hmastlock),
    .o_dbg_state (dbg_state),
    .o_dbg_cnt   (dbg_cnt)
  );

  always #5 hclk = ~hclk;

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic idle_inputs();
    hbusreq = 4'b0000; hlock = 4'b0000; htrans = IDLE; hburst = SINGLE;
    hready = 1'b1; hresp = OKAY;
  endtask

  task automatic test_reset();
    hresetn = 1'b0;
    idle_inputs();
    tick(); tick();
    hresetn = 1'b1;
    n_checks++; if (hgrant !== 4'b0001) begin n_fail++; $display("FAIL reset_grant: got %b expected 0001", hgrant); end
    n_checks++; if (hmaster !== 2'd0 || hmaster_d !== 2'd0) begin n_fail++; $display("FAIL reset_master: got %0d/%0d expected 0/0", hmaster, hmaster_d); end
    n_checks++; if (hmastlock !== 1'b0) begin n_fail++; $display("FAIL reset_mastlock: got %b expected 0", hmastlock); end
    n_checks++; if (dbg_state !== ST_ARB || dbg_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_fsm: got %0d/%0d expected ARB/0", dbg_state, dbg_cnt); end
    hbusreq = 4'b0100;
    tick();
    n_checks++; if (hgrant !== 4'b0100 || hmaster !== 2'd0) begin n_fail++; $display("FAIL first_grant: got %b/%0d expected 0100/0", hgrant, hmaster); end
    tick();
    n_checks++; if (hmaster !== 2'd2 || hmaster_d !== 2'd0) begin n_fail++; $display("FAIL hmaster_lag: got %0d/%0d expected 2/0", hmaster, hmaster_d); end
    tick();
    n_checks++; if (hmaster_d !== 2'd2) begin n_fail++; $display("FAIL hmaster_d_lag: got %0d expected 2", hmaster_d); end
    hbusreq = 4'b0000;
    tick();
    n_checks++; if (hgrant !== 4'b0001) begin n_fail++; $display("FAIL park_default: got %b expected 0001", hgrant); end
  endtask

  task automatic test_hold_and_drop();
    hbusreq = 4'b1000; hready = 1'b0;
    tick();
    n_checks++; if (hgrant !== 4'b0001) begin n_fail++; $display("FAIL hold_not_ready: got %b expected 0001", hgrant); end
    n_checks++; if (hmaster_d !== 2'd2) begin n_fail++; $display("FAIL hold_master_d: got %0d expected 2", hmaster_d); end
    hbusreq = 4'b0000; hready = 1'b1;
    tick();
    n_checks++; if (hgrant !== 4'b0001) begin n_fail++; $display("FAIL dropped_req: got %b expected 0001", hgrant); end
  endtask

  task automatic test_round_robin();
    int exp_idx[5] = '{1, 2, 3, 0, 1};
    hbusreq = 4'b1111; htrans = NONSEQ; hburst = SINGLE;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (hgrant !== (4'b0001 << exp_idx[i])) begin n_fail++; $display("FAIL rr_order step %0d: got %b expected master %0d", i, hgrant, exp_idx[i]); end
    end
    idle_inputs();
    tick();
    n_checks++; if (hgrant !== 4'b0001) begin n_fail++; $display("FAIL rr_park: got %b expected 0001", hgrant); end
  endtask

  task automatic test_incr_owner();
    hbusreq = 4'b0010;
    tick();
    hbusreq = 4'b1010; htrans = NONSEQ; hburst = INCR;
    tick();
    n_checks++; if (hgrant !== 4'b0010) begin n_fail++; $display("FAIL incr_keep_nonseq: got %b expected 0010", hgrant); end
    htrans = SEQ;
    tick(); tick();
    n_checks++; if (hgrant !== 4'b0010) begin n_fail++; $display("FAIL incr_keep_seq: got %b expected 0010", hgrant); end
    hbusreq = 4'b1000; htrans = IDLE;
    tick();
    n_checks++; if (hgrant !== 4'b1000) begin n_fail++; $display("FAIL incr_handover: got %b expected 1000", hgrant); end
    idle_inputs();
    tick();
    n_checks++; if (hgrant !== 4'b0001) begin n_fail++; $display("FAIL incr_park: got %b expected 0001", hgrant); end
  endtask

  task automatic test_incr8_burst();
    logic [1:0] tr[12] = '{SEQ, BUSY, SEQ, SEQ, SEQ, BUSY, SEQ, SEQ, SEQ, SEQ, SEQ, SEQ};
    logic       rd[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int   exp_cnt;
    hbusreq = 4'b0010;
    tick();
    hbusreq = 4'b1010; htrans = NONSEQ; hburst = INCR8;
    tick();
    n_checks++; if (hgrant !== 4'b0010 || dbg_state !== ST_BURST || dbg_cnt !== 4'd7) begin n_fail++; $display("FAIL incr8_start: got %b/%0d/%0d expected 0010/BURST/7", hgrant, dbg_state, dbg_cnt); end
    exp_cnt = 7;
    for (int i = 0; i < 12; i++) begin
      htrans = tr[i]; hready = rd[i];
      tick();
      if (tr[i] == SEQ && rd[i]) exp_cnt--;
      n_checks++; if (dbg_cnt !== 4'(exp_cnt)) begin n_fail++; $display("FAIL incr8_cnt step %0d: got %0d expected %0d", i, dbg_cnt, exp_cnt); end
      n_checks++; if (hgrant !== ((i == 11) ? 4'b1000 : 4'b0010)) begin n_fail++; $display("FAIL incr8_grant step %0d: got %b", i, hgrant); end
    end
    n_checks++; if (dbg_state !== ST_ARB) begin n_fail++; $display("FAIL incr8_end_state: got %0d expected ARB", dbg_state); end
    idle_inputs();
    tick();
    n_checks++; if (hgrant !== 4'b0001) begin n_fail++; $display("FAIL incr8_park: got %b expected 0001", hgrant); end
  endtask

  task automatic test_lock();
    hbusreq = 4'b0100; hlock = 4'b0100;
    tick();
    n_checks++; if (hgrant !== 4'b0100 || hmastlock !== 1'b0) begin n_fail++; $display("FAIL lock_grant: got %b/%b expected 0100/0", hgrant, hmastlock); end
    hbusreq = 4'b0111; htrans = NONSEQ; hburst = SINGLE;
    for (int i = 0; i < 4; i++) begin
      hready = (i != 2);
      tick();
      n_checks++; if (hgrant !== 4'b0100 || hmastlock !== 1'b1 || dbg_state !== ST_LOCKED) begin n_fail++; $display("FAIL lock_hold step %0d: got %b/%b/%0d expected 0100/1/LOCKED", i, hgrant, hmastlock, dbg_state); end
    end
    hlock = 4'b0000; hbusreq = 4'b0011; htrans = IDLE;
    tick();
    n_checks++; if (hgrant !== 4'b0001 || hmastlock !== 1'b0 || dbg_state !== ST_ARB) begin n_fail++; $display("FAIL lock_release: got %b/%b/%0d expected 0001/0/ARB", hgrant, hmastlock, dbg_state); end
    idle_inputs();
    tick();
  endtask

  task automatic test_retry_abort();
    hbusreq = 4'b0101; htrans = NONSEQ; hburst = INCR16;
    tick();
    n_checks++; if (hgrant !== 4'b0001 || dbg_cnt !== 4'd15) begin n_fail++; $display("FAIL incr16_start: got %b/%0d expected 0001/15", hgrant, dbg_cnt); end
    htrans = SEQ;
    for (int i = 0; i < 4; i++) tick();
    n_checks++; if (dbg_cnt !== 4'd11) begin n_fail++; $display("FAIL incr16_cnt: got %0d expected 11", dbg_cnt); end
    hready = 1'b0; hresp = RETRY;
    tick();
    n_checks++; if (dbg_state !== ST_BURST || dbg_cnt !== 4'd11 || hgrant !== 4'b0001) begin n_fail++; $display("FAIL retry_first_cycle: got %0d/%0d/%b expected BURST/11/0001", dbg_state, dbg_cnt, hgrant); end
    hready = 1'b1; htrans = IDLE;
    tick();
    n_checks++; if (dbg_state !== ST_ARB || dbg_cnt !== 4'd0 || hgrant !== 4'b0100) begin n_fail++; $display("FAIL retry_abort: got %0d/%0d/%b expected ARB/0/0100", dbg_state, dbg_cnt, hgrant); end
    idle_inputs();
    tick();
    n_checks++; if (hgrant !== 4'b0001) begin n_fail++; $display("FAIL retry_park: got %b expected 0001", hgrant); end
  endtask

  task automatic test_async_reset_mid_wrap4();
    hbusreq = 4'b0010;
    tick();
    htrans = NONSEQ; hburst = WRAP4;
    tick();
    htrans = SEQ;
    tick();
    n_checks++; if (dbg_state !== ST_BURST || dbg_cnt !== 4'd2 || hmaster !== 2'd1) begin n_fail++; $display("FAIL wrap4_mid: got %0d/%0d/%0d expected BURST/2/1", dbg_state, dbg_cnt, hmaster); end
    #2 hresetn = 1'b0;
    #1;
    n_checks++; if (hgrant !== 4'b0001 || hmaster !== 2'd0 || hmaster_d !== 2'd0 || hmastlock !== 1'b0) begin n_fail++; $display("FAIL async_reset_outputs: got %b/%0d/%0d/%b expected 0001/0/0/0", hgrant, hmaster, hmaster_d, hmastlock); end
    n_checks++; if (dbg_state !== ST_ARB || dbg_cnt !== 4'd0) begin n_fail++; $display("FAIL async_reset_fsm: got %0d/%0d expected ARB/0", dbg_state, dbg_cnt); end
    idle_inputs();
    tick();
    hresetn = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_hold_and_drop();
    test_round_robin();
    test_incr_owner();
    test_incr8_burst();
    test_lock();
    test_retry_abort();
    test_async_reset_mid_wrap4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lvc_ahb_arbiter.md
Name: lvc_ahb_arbiter

Overview:
- Multi-master AHB-Lite-to-AHB arbiter for the lvc_ahb environment.
- Shares one AHB bus among NUM_MST masters using hbusreq/hlock/hgrant.
- Drives hmaster (address-phase owner), hmaster_d (data-phase owner) and hmastlock for the address/write-data muxes.
- Round-robin arbitration with burst-aware and lock-aware handover; default master parks the bus.

Parameters:
- NUM_MST, 4, number of requesting masters (2..16).
- DEFAULT_MST, 0, master parked on the bus when no requests are pending.
- MW, $clog2(NUM_MST), width of the master index.

Ports:
- hclk  in  1  bus clock.
- hresetn  in  1  asynchronous active-low reset.
- hbusreq  in  NUM_MST  per-master bus request.
- hlock  in  NUM_MST  per-master locked-access request.
- htrans  in  2  muxed transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- hburst  in  3  muxed burst type (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7).
- hready  in  1  bus ready.
- hresp  in  2  slave response (OKAY=0, ERROR=1, RETRY=2, SPLIT=3).
- hgrant  out  NUM_MST  one-hot grant, registered.
- hmaster  out  MW  address-phase owner index.
- hmaster_d  out  MW  data-phase owner index (hmaster delayed by one hready=1 edge).
- hmastlock  out  1  current address phase is locked.

Behaviour:
- Reset: hgrant = one-hot(DEFAULT_MST); hmaster = hmaster_d = DEFAULT_MST; hmastlock = 0; FSM = ARB; beat counter = 0; RR pointer = DEFAULT_MST.
- All outputs are registered. No combinational path from inputs to outputs.
- Ownership transfer: on every posedge with hready=1, hmaster <= index(hgrant) and hmaster_d <= hmaster. With hready=0 both hold.
- hmastlock <= hlock[index(hgrant)] on edges with hready=1.
- FSM states: ARB, BURST, LOCKED.
  - ARB (arbitration point):
    - Each cycle, select the winner among hbusreq by round robin, starting search at RR pointer+1, wrapping.
    - No request: winner = DEFAULT_MST.
    - hgrant updates to the winner only when hready=1; the RR pointer then becomes the winner.
    - With hready=0, hgrant holds.
  - ARB -> BURST: hready=1 and htrans=NONSEQ with a fixed-length hburst (WRAP4..INCR16). Beat counter loads len-1 (3/7/15). hgrant is frozen.
  - BURST:
    - Counter decrements on hready=1 with htrans=SEQ. BUSY does not decrement.
    - Return to ARB when hready=1 and the counter is 0 on a SEQ, or htrans=IDLE/NONSEQ is seen (early termination).
    - The last beat is itself an arbitration cycle: a new grant is computed in that same cycle, so handover costs no dead cycle.
  - INCR and SINGLE stay in ARB. For INCR, the owner keeps the grant while its hbusreq remains asserted: the owner wins ties ahead of round robin. Handover happens after it drops hbusreq.
  - LOCKED:
    - Entered from ARB/BURST when hready=1, htrans=NONSEQ and hlock[owner]=1.
    - Grant is frozen regardless of other requests.
    - Exit to ARB when hready=1 and hlock[owner]=0 with htrans in {IDLE, NONSEQ}.
- Responses:
  - ERROR, RETRY or SPLIT on the hready=1 cycle (second response cycle): counter <= 0, FSM -> ARB, regardless of burst or lock state.
  - On RETRY/SPLIT the responding master's request stays eligible; no split masking.
- Simultaneous events:
  - Lock and burst start together -> LOCKED (lock dominates; the counter still loads and still tracks beats).
  - Reset mid-burst returns to the reset state immediately (async).
- A request dropped in the same cycle the grant would issue is not granted.
- hgrant is always exactly one-hot.

Decomposition:
- Shared package lvc_ahb_pkg (already present) supplies trans_type_enum, burst_type_enum and response_type_enum.
- Add to the package a function burst_len(burst_type_enum) returning the beat count (1/0/4/4/8/8/16/16, with 0 meaning undefined INCR).
- One sub-module: lvc_ahb_rr_picker.
  - Combinational round-robin selector with inputs req[NUM_MST] and ptr[MW].
  - Outputs: winner index and a valid flag.
  - Reusable by the slave-side decoder bench.

Test Plan:
- Reset, no requests -> hgrant=4'b0001, hmaster=0, hmastlock=0. Then hbusreq=4'b0100 with hready=1 -> hgrant=4'b0100 next edge, hmaster=2 one edge later.
- Round robin: hbusreq=4'b1111 held, each master issues SINGLE -> grant order 1,2,3,0,1.
- INCR8 burst by master 1, master 3 requesting -> hgrant stays 4'b0010 for 8 SEQ/NONSEQ beats incl. 2 BUSY and 3 hready=0 cycles. hgrant=4'b1000 on the 8th beat's hready=1 edge.
- Lock: master 2 hlock=1 doing 3 SINGLEs, masters 0/1 requesting -> no grant change and hmastlock=1 throughout. Release after hlock=0 + IDLE.
- RETRY mid-INCR16 at beat 5 (two-cycle response) -> FSM ARB, counter 0, next grant by round robin in the same cycle.
- Assert hresetn=0 mid-WRAP4 -> outputs return to reset values asynchronously, before the next hclk edge.
